// File: rtl/tri_setup_if.sv
// ---------------------------------------------------------------------------
// tri_setup_if: triangle/vertex table reads and setup-entry write bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tri_setup_if;
  logic [3:0]         tri_idx;
  logic [2:0]         tri_v0;
  logic [2:0]         tri_v1;
  logic [2:0]         tri_v2;
  logic [11:0]        tri_color;
  logic [2:0]         vert_idx;
  logic [9:0]         vert_x;
  logic [9:0]         vert_y;
  logic               set_we;
  logic [3:0]         set_addr;
  logic [9:0]         set_min_x;
  logic [9:0]         set_max_x;
  logic [9:0]         set_min_y;
  logic [9:0]         set_max_y;
  logic signed [21:0] set_area;
  logic [3:0]         set_bright;
  logic [11:0]        set_color;

  modport master (
    output tri_idx, vert_idx,
    output set_we, set_addr, set_min_x, set_max_x, set_min_y, set_max_y,
    output set_area, set_bright, set_color,
    input  tri_v0, tri_v1, tri_v2, tri_color, vert_x, vert_y
  );

  modport slave (
    input  tri_idx, vert_idx,
    input  set_we, set_addr, set_min_x, set_max_x, set_min_y, set_max_y,
    input  set_area, set_bright, set_color,
    output tri_v0, tri_v1, tri_v2, tri_color, vert_x, vert_y
  );
endinterface

`default_nettype wire

// File: rtl/tri_setup_sequencer.sv
// ---------------------------------------------------------------------------
// tri_setup_sequencer: per-frame triangle setup (bbox, signed area, culling)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tri_setup_sequencer #(
  parameter int MAX_TRI  = 12,
  parameter int NUM_VERT = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       frame,
  input  wire logic [3:0] num_triangles,
  tri_setup_if.master     bus,
  output logic            busy,
  output logic            done,
  output logic [3:0]      num_visible,
  output logic            overrun
);

  localparam logic [2:0] c_idle      = 3'd0;
  localparam logic [2:0] c_fetch_tri = 3'd1;
  localparam logic [2:0] c_fetch_a   = 3'd2;
  localparam logic [2:0] c_fetch_b   = 3'd3;
  localparam logic [2:0] c_fetch_c   = 3'd4;
  localparam logic [2:0] c_compute   = 3'd5;
  localparam logic [2:0] c_write     = 3'd6;
  localparam logic [2:0] c_done      = 3'd7;

  localparam logic [3:0] c_max_tri   = 4'(MAX_TRI);
  localparam logic [2:0] c_vert_last = 3'(NUM_VERT - 1);
  localparam logic [3:0] c_min_bright = 4'h6;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;

  logic [3:0]  r_n;
  logic [3:0]  r_t;
  logic [3:0]  r_wp;
  logic [3:0]  r_num_visible;
  logic        r_overrun;
  logic [2:0]  r_v0, r_v1, r_v2;
  logic [11:0] r_color;
  logic [9:0]  r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
  logic        r_front;

  logic [3:0]         r_set_addr;
  logic [9:0]         r_set_min_x, r_set_max_x, r_set_min_y, r_set_max_y;
  logic signed [21:0] r_set_area;
  logic [3:0]         r_set_bright;
  logic [11:0]        r_set_color;

  logic [3:0]  w_n;
  logic [9:0]  w_min_x_ab, w_min_x, w_max_x_ab, w_max_x;
  logic [9:0]  w_min_y_ab, w_min_y, w_max_y_ab, w_max_y;
  logic signed [10:0] w_dx_ab, w_dy_ab, w_dx_ac, w_dy_ac;
  logic signed [21:0] w_dx_ab_e, w_dy_ab_e, w_dx_ac_e, w_dy_ac_e;
  logic signed [21:0] w_area;
  logic [3:0]  w_nib;
  logic [3:0]  w_bright;

  assign w_n = (num_triangles > c_max_tri) ? c_max_tri : num_triangles;

  // Bounding box over the three latched vertices
  assign w_min_x_ab = (r_ax < r_bx) ? r_ax : r_bx;
  assign w_min_x    = (w_min_x_ab < r_cx) ? w_min_x_ab : r_cx;
  assign w_max_x_ab = (r_ax > r_bx) ? r_ax : r_bx;
  assign w_max_x    = (w_max_x_ab > r_cx) ? w_max_x_ab : r_cx;
  assign w_min_y_ab = (r_ay < r_by) ? r_ay : r_by;
  assign w_min_y    = (w_min_y_ab < r_cy) ? w_min_y_ab : r_cy;
  assign w_max_y_ab = (r_ay > r_by) ? r_ay : r_by;
  assign w_max_y    = (w_max_y_ab > r_cy) ? w_max_y_ab : r_cy;

  assign w_dx_ab = $signed({1'b0, r_bx}) - $signed({1'b0, r_ax});
  assign w_dy_ab = $signed({1'b0, r_by}) - $signed({1'b0, r_ay});
  assign w_dx_ac = $signed({1'b0, r_cx}) - $signed({1'b0, r_ax});
  assign w_dy_ac = $signed({1'b0, r_cy}) - $signed({1'b0, r_ay});

  assign w_dx_ab_e = {{11{w_dx_ab[10]}}, w_dx_ab};
  assign w_dy_ab_e = {{11{w_dy_ab[10]}}, w_dy_ab};
  assign w_dx_ac_e = {{11{w_dx_ac[10]}}, w_dx_ac};
  assign w_dy_ac_e = {{11{w_dy_ac[10]}}, w_dy_ac};

  assign w_area   = (w_dx_ab_e * w_dy_ac_e) - (w_dy_ab_e * w_dx_ac_e);
  assign w_nib    = 4'((-w_area) >>> 10);
  assign w_bright = (w_area[21] && (w_nib > c_min_bright)) ? w_nib : c_min_bright;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:      if (frame) w_next_state = (w_n == 4'd0) ? c_done : c_fetch_tri;
      c_fetch_tri: w_next_state = c_fetch_a;
      c_fetch_a:   w_next_state = c_fetch_b;
      c_fetch_b:   w_next_state = c_fetch_c;
      c_fetch_c:   w_next_state = c_compute;
      c_compute:   w_next_state = c_write;
      c_write:     w_next_state = (r_t == r_n - 4'd1) ? c_done : c_fetch_tri;
      c_done:      w_next_state = c_idle;
      default:     w_next_state = c_idle;
    endcase
  end

  always_comb begin
    busy         = (r_state != c_idle);
    done         = (r_state == c_done);
    bus.set_we   = (r_state == c_write) && r_front;
    bus.tri_idx  = (r_state == c_fetch_tri) ? r_t : 4'd0;
    bus.vert_idx = 3'd0;
    case (r_state)
      c_fetch_a: bus.vert_idx = r_v0;
      c_fetch_b: bus.vert_idx = r_v1;
      c_fetch_c: bus.vert_idx = r_v2;
      default:   bus.vert_idx = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n           <= '0;
      r_t           <= '0;
      r_wp          <= '0;
      r_num_visible <= '0;
      r_overrun     <= 1'b0;
      r_v0          <= '0;
      r_v1          <= '0;
      r_v2          <= '0;
      r_color       <= '0;
      r_ax          <= '0;
      r_ay          <= '0;
      r_bx          <= '0;
      r_by          <= '0;
      r_cx          <= '0;
      r_cy          <= '0;
      r_front       <= 1'b0;
      r_set_addr    <= '0;
      r_set_min_x   <= '0;
      r_set_max_x   <= '0;
      r_set_min_y   <= '0;
      r_set_max_y   <= '0;
      r_set_area    <= '0;
      r_set_bright  <= '0;
      r_set_color   <= '0;
    end else begin
      if (frame && (r_state != c_idle)) r_overrun <= 1'b1;
      case (r_state)
        c_idle: begin
          if (frame) begin
            r_n           <= w_n;
            r_t           <= '0;
            r_wp          <= '0;
            r_num_visible <= '0;
          end
        end
        c_fetch_tri: begin
          // Out-of-range vertex indices are pinned to the last table entry
          r_v0    <= (bus.tri_v0 > c_vert_last) ? c_vert_last : bus.tri_v0;
          r_v1    <= (bus.tri_v1 > c_vert_last) ? c_vert_last : bus.tri_v1;
          r_v2    <= (bus.tri_v2 > c_vert_last) ? c_vert_last : bus.tri_v2;
          r_color <= bus.tri_color;
        end
        c_fetch_a: begin
          r_ax <= bus.vert_x;
          r_ay <= bus.vert_y;
        end
        c_fetch_b: begin
          r_bx <= bus.vert_x;
          r_by <= bus.vert_y;
        end
        c_fetch_c: begin
          r_cx <= bus.vert_x;
          r_cy <= bus.vert_y;
        end
        c_compute: begin
          // Output fields only move for front-facing triangles so they hold otherwise
          r_front <= w_area[21];
          if (w_area[21]) begin
            r_set_addr   <= r_wp;
            r_set_min_x  <= w_min_x;
            r_set_max_x  <= w_max_x;
            r_set_min_y  <= w_min_y;
            r_set_max_y  <= w_max_y;
            r_set_area   <= w_area;
            r_set_bright <= w_bright;
            r_set_color  <= r_color;
          end
        end
        c_write: begin
          if (r_front) begin
            r_num_visible <= r_num_visible + 4'd1;
            if (r_wp != r_n - 4'd1) r_wp <= r_wp + 4'd1;
          end
          if (r_t != r_n - 4'd1) r_t <= r_t + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign num_visible    = r_num_visible;
  assign overrun        = r_overrun;
  assign bus.set_addr   = r_set_addr;
  assign bus.set_min_x  = r_set_min_x;
  assign bus.set_max_x  = r_set_max_x;
  assign bus.set_min_y  = r_set_min_y;
  assign bus.set_max_y  = r_set_max_y;
  assign bus.set_area   = r_set_area;
  assign bus.set_bright = r_set_bright;
  assign bus.set_color  = r_set_color;

endmodule

`default_nettype wire
